// File: rtl/ssd_scan_ctrl_if.sv
// ----------------------------------------------------------------------------
// ssd_scan_ctrl_if
//   Bus between a display-data producer and the seven-segment scan scheduler.
//   master : producer side (drives enable, load strobe and display data;
//            observes the scan outputs).
//   slave  : scheduler side (ssd_scan_ctrl).
//   Signals:
//     ssd_scan_ctrl_en          1   scan enable
//     ssd_scan_ctrl_load        1   1-cycle strobe, capture data/dp/mask
//     ssd_scan_ctrl_data        32  8 nibbles, digit k = data[4k+3:4k]
//     ssd_scan_ctrl_dp          8   decimal-point request per digit
//     ssd_scan_ctrl_mask        8   digit enable per digit
//     ssd_scan_ctrl_nibble      4   nibble of the current digit
//     ssd_scan_ctrl_dp_out      1   dp request of the current digit
//     ssd_scan_ctrl_an          8   anodes, active-low
//     ssd_scan_ctrl_frame_done  1   pulse at end of digit 7 slot
//     ssd_scan_ctrl_pending     1   shadow holds data not yet applied
// ----------------------------------------------------------------------------
interface ssd_scan_ctrl_if;
   logic        ssd_scan_ctrl_en;
   logic        ssd_scan_ctrl_load;
   logic [31:0] ssd_scan_ctrl_data;
   logic [7:0]  ssd_scan_ctrl_dp;
   logic [7:0]  ssd_scan_ctrl_mask;
   logic [3:0]  ssd_scan_ctrl_nibble;
   logic        ssd_scan_ctrl_dp_out;
   logic [7:0]  ssd_scan_ctrl_an;
   logic        ssd_scan_ctrl_frame_done;
   logic        ssd_scan_ctrl_pending;

   modport master (
      output ssd_scan_ctrl_en, ssd_scan_ctrl_load, ssd_scan_ctrl_data,
             ssd_scan_ctrl_dp, ssd_scan_ctrl_mask,
      input  ssd_scan_ctrl_nibble, ssd_scan_ctrl_dp_out, ssd_scan_ctrl_an,
             ssd_scan_ctrl_frame_done, ssd_scan_ctrl_pending
   );

   modport slave (
      input  ssd_scan_ctrl_en, ssd_scan_ctrl_load, ssd_scan_ctrl_data,
             ssd_scan_ctrl_dp, ssd_scan_ctrl_mask,
      output ssd_scan_ctrl_nibble, ssd_scan_ctrl_dp_out, ssd_scan_ctrl_an,
             ssd_scan_ctrl_frame_done, ssd_scan_ctrl_pending
   );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// ----------------------------------------------------------------------------
// ssd_scan_ctrl
//   Time-multiplexing scheduler for an 8-digit seven-segment display. Cycles
//   the anodes one digit at a time, with an all-off blanking gap before every
//   digit to suppress ghosting. Display data is double-buffered: loads go to
//   a shadow copy which becomes active at the frame boundary (end of digit 7).
//   Ports:
//     ssd_scan_ctrl_clk  in   system clock
//     ssd_scan_ctrl_rst  in   asynchronous reset, active-high
//     bus                     ssd_scan_ctrl_if.slave (see interface header)
//   Parameters:
//     refresh_div   clocks each digit is driven per slot (>= 1)
//     blank_cycles  clocks all anodes are off before each digit slot (>= 1)
// ----------------------------------------------------------------------------
module ssd_scan_ctrl #(
   parameter int unsigned refresh_div  = 100000,
   parameter int unsigned blank_cycles = 1000
) (
   input  logic           ssd_scan_ctrl_clk,
   input  logic           ssd_scan_ctrl_rst,
   ssd_scan_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } state_e;

   localparam logic [31:0] blank_last = 32'(blank_cycles - 1);
   localparam logic [31:0] drive_last = 32'(refresh_div - 1);

   state_e      state_q;
   logic [31:0] timer_q;
   logic [2:0]  idx_q;

   logic [31:0] act_data_q, shd_data_q;
   logic [7:0]  act_dp_q, shd_dp_q;
   logic [7:0]  act_mask_q, shd_mask_q;
   logic        pending_q;

   logic [3:0]  nibble_q;
   logic        dp_out_q;
   logic [7:0]  an_q;
   logic        frame_done_q;

   logic [31:0] act_data_d;
   logic [7:0]  act_dp_d;
   logic [7:0]  act_mask_d;
   logic        pending_d;
   logic        commit;
   logic        load_direct;
   logic [2:0]  idx_next;

   // Frame boundary: last clock of the digit 7 drive slot while still enabled.
   assign commit = bus.ssd_scan_ctrl_en && (state_q == DRIVE) &&
                   (idx_q == 3'd7) && (timer_q == drive_last);

   // A load goes straight to the active copy when nothing is being displayed
   // (IDLE) or when it coincides with the commit, so it is never lost.
   assign load_direct = bus.ssd_scan_ctrl_load && ((state_q == IDLE) || commit);

   // Digit index wraps 7 -> 0 naturally in 3 bits.
   assign idx_next = idx_q + 3'd1;

   // NOTE: every always_comb output gets a default first, so no path leaves a
   // value unassigned and no latch is inferred.
   always_comb begin
      act_data_d = act_data_q;
      act_dp_d   = act_dp_q;
      act_mask_d = act_mask_q;
      pending_d  = pending_q;

      if (load_direct) begin
         act_data_d = bus.ssd_scan_ctrl_data;
         act_dp_d   = bus.ssd_scan_ctrl_dp;
         act_mask_d = bus.ssd_scan_ctrl_mask;
      end else if (commit) begin
         act_data_d = shd_data_q;
         act_dp_d   = shd_dp_q;
         act_mask_d = shd_mask_q;
      end

      if (load_direct || commit) begin
         pending_d = 1'b0;
      end else if (bus.ssd_scan_ctrl_load) begin
         pending_d = 1'b1;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge ssd_scan_ctrl_clk or posedge ssd_scan_ctrl_rst) begin
      if (ssd_scan_ctrl_rst) begin
         state_q      <= IDLE;
         timer_q      <= '0;
         idx_q        <= '0;
         act_data_q   <= '0;
         act_dp_q     <= '0;
         act_mask_q   <= '0;
         shd_data_q   <= '0;
         shd_dp_q     <= '0;
         shd_mask_q   <= '0;
         pending_q    <= 1'b0;
         nibble_q     <= '0;
         dp_out_q     <= 1'b0;
         an_q         <= 8'hFF;
         frame_done_q <= 1'b0;
      end else begin
         act_data_q   <= act_data_d;
         act_dp_q     <= act_dp_d;
         act_mask_q   <= act_mask_d;
         pending_q    <= pending_d;
         frame_done_q <= 1'b0;

         if (bus.ssd_scan_ctrl_load) begin
            shd_data_q <= bus.ssd_scan_ctrl_data;
            shd_dp_q   <= bus.ssd_scan_ctrl_dp;
            shd_mask_q <= bus.ssd_scan_ctrl_mask;
         end

         if (!bus.ssd_scan_ctrl_en) begin
            state_q <= IDLE;
            idx_q   <= '0;
            timer_q <= '0;
            an_q    <= 8'hFF;
         end else begin
            unique case (state_q)
               IDLE: begin
                  state_q  <= BLANK;
                  timer_q  <= '0;
                  idx_q    <= '0;
                  an_q     <= 8'hFF;
                  nibble_q <= act_data_d[3:0];
                  dp_out_q <= act_dp_d[0];
               end

               BLANK: begin
                  if (timer_q == blank_last) begin
                     state_q <= DRIVE;
                     timer_q <= '0;
                     // A masked digit keeps its slot timing but stays dark.
                     an_q    <= act_mask_d[idx_q] ? ~(8'b1 << idx_q) : 8'hFF;
                  end else begin
                     timer_q <= timer_q + 32'd1;
                  end
               end

               DRIVE: begin
                  if (timer_q == drive_last) begin
                     state_q      <= BLANK;
                     timer_q      <= '0;
                     idx_q        <= idx_next;
                     an_q         <= 8'hFF;
                     // Uses the post-commit copy so digit 0 of a new frame
                     // already shows freshly committed data.
                     nibble_q     <= act_data_d[{idx_next, 2'b00} +: 4];
                     dp_out_q     <= act_dp_d[idx_next];
                     frame_done_q <= (idx_q == 3'd7);
                  end else begin
                     timer_q <= timer_q + 32'd1;
                  end
               end

               default: begin
                  state_q <= IDLE;
                  timer_q <= '0;
                  idx_q   <= '0;
                  an_q    <= 8'hFF;
               end
            endcase
         end
      end
   end

   assign bus.ssd_scan_ctrl_nibble     = nibble_q;
   assign bus.ssd_scan_ctrl_dp_out     = dp_out_q;
   assign bus.ssd_scan_ctrl_an         = an_q;
   assign bus.ssd_scan_ctrl_frame_done = frame_done_q;
   assign bus.ssd_scan_ctrl_pending    = pending_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ssd_scan_ctrl
//   Self-checking bench for ssd_scan_ctrl with refresh_div=4, blank_cycles=2.
//   The reference model tracks how many clocks the scanner has been running
//   and derives slot, phase and frame boundary from that with plain
//   arithmetic; display buffers are modelled as simple variables.
// ----------------------------------------------------------------------------
module tb_ssd_scan_ctrl;
   localparam int rdiv      = 4;
   localparam int bcyc      = 2;
   localparam int slot_len  = rdiv + bcyc;
   localparam int frame_len = 8 * slot_len;

   logic clk = 1'b0;
   logic rst;

   ssd_scan_ctrl_if bus ();

   ssd_scan_ctrl #(
      .refresh_div  (rdiv),
      .blank_cycles (bcyc)
   ) dut (
      .ssd_scan_ctrl_clk (clk),
      .ssd_scan_ctrl_rst (rst),
      .bus               (bus)
   );

   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Reference model state
   int          age;           // clocks since scanning started, 0 = idle
   logic [31:0] m_act_data, m_shd_data;
   logic [7:0]  m_act_dp, m_shd_dp, m_act_mask, m_shd_mask;
   logic        m_pending;
   logic [3:0]  m_nibble;
   logic        m_dp_out;
   logic [7:0]  m_an;
   logic        m_fd;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      age        = 0;
      m_act_data = '0; m_shd_data = '0;
      m_act_dp   = '0; m_shd_dp   = '0;
      m_act_mask = '0; m_shd_mask = '0;
      m_pending  = 1'b0;
      m_nibble   = '0;
      m_dp_out   = 1'b0;
      m_an       = 8'hFF;
      m_fd       = 1'b0;
   endtask

   // One clock edge of the reference model, using the inputs held across it.
   task automatic model_edge();
      bit was_idle;
      bit commit;
      bit ld;
      int p, slot, off;
      was_idle = (age == 0);
      commit   = 1'b0;
      p        = 0;
      ld       = bus.ssd_scan_ctrl_load;
      if (bus.ssd_scan_ctrl_en) begin
         age++;
         p      = (age - 1) % frame_len;
         commit = (age > 1) && (p == 0);
      end else begin
         age = 0;
      end

      if (ld && (was_idle || commit)) begin
         m_act_data = bus.ssd_scan_ctrl_data;
         m_act_dp   = bus.ssd_scan_ctrl_dp;
         m_act_mask = bus.ssd_scan_ctrl_mask;
      end else if (commit) begin
         m_act_data = m_shd_data;
         m_act_dp   = m_shd_dp;
         m_act_mask = m_shd_mask;
      end
      if (commit || (ld && was_idle)) m_pending = 1'b0;
      else if (ld)                    m_pending = 1'b1;
      if (ld) begin
         m_shd_data = bus.ssd_scan_ctrl_data;
         m_shd_dp   = bus.ssd_scan_ctrl_dp;
         m_shd_mask = bus.ssd_scan_ctrl_mask;
      end

      if (age == 0) begin
         m_an = 8'hFF;
         m_fd = 1'b0;
      end else begin
         slot     = p / slot_len;
         off      = p % slot_len;
         m_fd     = commit;
         m_an     = (off < bcyc || !m_act_mask[slot]) ? 8'hFF : ~(8'b1 << slot);
         m_nibble = m_act_data[slot*4 +: 4];
         m_dp_out = m_act_dp[slot];
      end
   endtask

   task automatic compare_outputs(input string ctx);
      check({ctx, ".an"},         32'(bus.ssd_scan_ctrl_an),         32'(m_an));
      check({ctx, ".nibble"},     32'(bus.ssd_scan_ctrl_nibble),     32'(m_nibble));
      check({ctx, ".dp_out"},     32'(bus.ssd_scan_ctrl_dp_out),     32'(m_dp_out));
      check({ctx, ".frame_done"}, 32'(bus.ssd_scan_ctrl_frame_done), 32'(m_fd));
      check({ctx, ".pending"},    32'(bus.ssd_scan_ctrl_pending),    32'(m_pending));
   endtask

   task automatic step(input string ctx);
      @(posedge clk);
      model_edge();
      #1;
      compare_outputs(ctx);
      bus.ssd_scan_ctrl_load = 1'b0;
   endtask

   task automatic run(input string ctx, input int n);
      for (int i = 0; i < n; i++) step(ctx);
   endtask

   task automatic set_load(input logic [31:0] d, input logic [7:0] dp,
                           input logic [7:0] mask);
      bus.ssd_scan_ctrl_load = 1'b1;
      bus.ssd_scan_ctrl_data = d;
      bus.ssd_scan_ctrl_dp   = dp;
      bus.ssd_scan_ctrl_mask = mask;
   endtask

   // Is the model currently in the drive phase of digit k?
   function automatic bit in_drive(input int k);
      int p;
      if (age == 0) return 1'b0;
      p = (age - 1) % frame_len;
      return ((p / slot_len) == k) && ((p % slot_len) >= bcyc);
   endfunction

   initial begin
      bus.ssd_scan_ctrl_en   = 1'b0;
      bus.ssd_scan_ctrl_load = 1'b0;
      bus.ssd_scan_ctrl_data = '0;
      bus.ssd_scan_ctrl_dp   = '0;
      bus.ssd_scan_ctrl_mask = '0;
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_outputs("reset");
      rst = 1'b0;

      // IDLE load then enable: full frame of digits 0..7
      set_load(32'h7654_3210, 8'hA5, 8'hFF);
      step("idle_load");
      bus.ssd_scan_ctrl_en = 1'b1;
      run("frame1", frame_len + 6);

      // Mid-frame load stays in shadow until the frame boundary
      for (int i = 0; i < frame_len && !in_drive(2); i++) step("seek2");
      check("seek_digit2", 32'(in_drive(2)), 32'd1);
      set_load(32'h89AB_CDEF, 8'h0F, 8'hFF);
      run("midload", frame_len + 8);

      // Load coincident with the commit edge
      for (int i = 0; i < frame_len + 1 && !((age % frame_len) == 0); i++)
         step("seek_commit");
      check("seek_commit", 32'(age % frame_len), 32'd0);
      set_load(32'h0000_000A, 8'h01, 8'hFF);
      run("coincident", 12);

      // Sparse mask, loaded through IDLE
      bus.ssd_scan_ctrl_en = 1'b0;
      step("disable");
      set_load(32'h1357_9BDF, 8'h00, 8'b0000_0101);
      step("mask_load");
      bus.ssd_scan_ctrl_en = 1'b1;
      run("mask", 2 * frame_len + 2);

      // en dropped during digit 5 drive, then re-raised
      for (int i = 0; i < frame_len && !in_drive(5); i++) step("seek5");
      check("seek_digit5", 32'(in_drive(5)), 32'd1);
      bus.ssd_scan_ctrl_en = 1'b0;
      step("en_drop");
      bus.ssd_scan_ctrl_en = 1'b1;
      run("reenable", 10);

      // Async reset mid-drive of digit 3 with pending shadow data
      set_load(32'hFEDC_BA98, 8'hFF, 8'hFF);
      step("pre_reset_load");
      for (int i = 0; i < frame_len && !in_drive(3); i++) step("seek3");
      check("seek_digit3", 32'(in_drive(3)), 32'd1);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      compare_outputs("async_reset");
      #3;
      rst = 1'b0;
      run("after_reset", frame_len + 4);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bus.ssd_scan_ctrl_en = ($urandom_range(0, 149) != 0);
         if ($urandom_range(0, 15) == 0)
            set_load($urandom, 8'($urandom), 8'($urandom));
         step("rand");
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
